// File: rtl/decoder532_arbiter.sv
// Round-robin arbiter granting one of 32 requesters the decoder532 select fabric.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module decoder532_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  input  logic        done,
  output logic [4:0]  a,
  output logic        sta,
  output logic        stb,
  output logic        stc,
  output logic        gnt_valid,
  output logic        timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX out of range 2..255");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [4:0] ptr_q, ptr_d;
  logic [4:0] a_q, a_d;
  logic       timeout_q, timeout_d;
  logic       hold_expired;

  logic       pick_found;
  logic [4:0] pick_idx;
  logic [4:0] scan_idx;

  // First set request at or after ptr, wrapping modulo 32.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int i = 0; i < 32; i++) begin
      scan_idx = ptr_q + 5'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hcnt_q, hcnt_d;

  assign hold_expired = (hcnt_q == 8'(HOLD_MAX - 1));

  always_comb begin
    hcnt_d = hcnt_q;
    if (state_q == StIdle) begin
      hcnt_d = 8'd0;
    end else if (hcnt_q != 8'hFF) begin
      hcnt_d = hcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= 8'd0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          a_d     = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (done || !req[a_q] || hold_expired) begin
          ptr_d     = a_q + 5'd1;
          state_d   = StIdle;
          // Only a release caused solely by the hold limit counts as a timeout.
          timeout_d = hold_expired && !done && req[a_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 5'd0;
      a_q       <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      timeout_q <= timeout_d;
    end
  end

  assign a         = a_q;
  assign gnt_valid = (state_q == StGrant);
  assign sta       = (state_q == StGrant);
  assign stb       = (state_q != StGrant);
  assign stc       = (state_q != StGrant);
  assign timeout   = timeout_q;

endmodule

// File: doc/decoder532_arbiter.md
# decoder532_arbiter

Round-robin arbiter that shares the decoder532 one-hot select fabric among 32 requesters. It picks one pending requester, drives its 5-bit index plus the three decoder enables so exactly one decoder line is active, and holds the grant until the owner releases it. It sits directly in front of decoder532: `a` feeds the decoder address and `sta`/`stb`/`stc` feed its enables.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive grant cycles before a forced release. Only used when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 32: request vector; bit i set means requester i wants the decoder line.
- `done` in 1: current owner releases its grant; sampled only in GRANT.
- `a` out 5: decoder address, registered.
- `sta` out 1: decoder enable G1; 1 while granted.
- `stb` out 1: decoder enable G2A, active-low; 0 while granted.
- `stc` out 1: decoder enable G2B, active-low; 0 while granted.
- `gnt_valid` out 1: a grant is active and `a` is valid.
- `timeout` out 1: one-cycle pulse when a grant is force-released.

## Operation
- The state register has two states, IDLE and GRANT. There is also a 5-bit priority pointer `ptr` and an 8-bit hold counter `hcnt`.
- **IDLE**
  - If `req` is nonzero, select the first set bit found scanning `ptr`, `ptr+1`, … 31, 0, … `ptr-1`, wrapping modulo 32.
  - Load that index into `a`, clear `hcnt`, and go to GRANT.
  - If `req` is zero, remain in IDLE.
- **GRANT**
  - `hcnt` increments each cycle and saturates at 255.
  - Release happens on the first cycle where any of the following holds:
    - `done` is 1;
    - `req[a]` is 0 (requester withdrew);
    - `ARB_TIMEOUT_EN` is defined and `hcnt == HOLD_MAX-1`.
  - On release:
    - set `ptr = a+1` modulo 32, so 31 wraps to 0;
    - go to IDLE.
  - The force-release case additionally pulses `timeout` for one cycle.
  - If `done` and the timeout condition coincide, this is a normal release: `timeout` stays 0.
- **Output encoding**
  - IDLE: `sta=0`, `stb=1`, `stc=1`. All decoder lines are inactive and `a` holds its last value.
  - GRANT: `sta=1`, `stb=0`, `stc=0`, `gnt_valid=1`.
- All outputs are registered. No combinational path exists from `req` or `done` to any output.
- Requests are level-sensitive. A requester keeps `req` high until it is granted.

## Timing
- **Reset values:** state=IDLE, `ptr=0`, `hcnt=0`, `a=0`, `sta=0`, `stb=1`, `stc=1`, `gnt_valid=0`, `timeout=0`.
- **Grant latency:** `req` seen high at edge N in IDLE gives `gnt_valid`/`a`/enables valid after edge N, i.e. one cycle.
- **Release latency:** `done` sampled at edge M gives `gnt_valid=0` and enables idle after edge M.
- **Mandatory gap:** one IDLE cycle always separates consecutive grants. Back-to-back requests are granted every other edge at best.
- **Maximum grant length** with the timeout enabled is `HOLD_MAX` cycles of `gnt_valid`.
- **Reset mid-grant:** on the reset edge everything returns to reset values. `timeout` does not pulse.
- **`done` in IDLE** is ignored.
- **Changes to `req` bits other than `req[a]`** during GRANT have no effect until the next IDLE.

## Configuration
- Macro `ARB_TIMEOUT_EN`:
  - **Defined:** the `hcnt`/`HOLD_MAX` forced release is active, and `timeout` pulses as specified.
  - **Undefined:** grants end only on `done` or request withdrawal. `timeout` is tied to 0. `hcnt` may be removed; `HOLD_MAX` is ignored.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req=32'hFFFF_FFFF`. Outputs stay at reset values (`sta=0`, `stb=1`, `stc=1`, `a=0`) during reset. Grant to index 0 appears one cycle after `rst` drops.
- **Round robin:** set `req=32'h8000_0011` and pulse `done` each grant. The grant order is 0, 4, 31, 0, 4. Each grant is separated by exactly one cycle with `gnt_valid=0`.
- **Wrap-around:**
  - Grant index 31 (`req=32'h8000_0000`), then release.
  - Then set `req=32'h0000_0003`.
  - The next grant is index 0.
- **Withdrawal:** grant index 5, drop `req[5]` with `done=0`. `gnt_valid` falls after the next edge. `ptr` becomes 6, shown by the next grant order with `req=32'h0000_0060` being 6.
- **Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX=4`):**
  - Hold `req[2]=1` with `done=0`.
  - `gnt_valid` stays high exactly 4 cycles.
  - `timeout` pulses for 1 cycle at release, and the next grant goes to index 2 again after the gap.
  - Without the macro, `gnt_valid` stays high for 100 or more cycles and `timeout` stays 0.
- **Reset mid-grant:** assert `rst` while index 9 is granted. The next cycle shows `sta=0`, `gnt_valid=0`, `a=0`. After reset, with `req` bits 9 and 1 set, the first grant is index 1.
